// File: rtl/addsub_arbiter.sv
// Two-port arbiter sharing one saturating 16-bit adder/subtractor.
// Each port owns a single-entry result buffer held until acknowledged.
module AddSub_16bit (
  input  logic [15:0] a_i,
  input  logic [15:0] b_i,
  input  logic        sub_i,
  output logic [15:0] sum_o,
  output logic        ovfl_o
);
  logic [16:0] a_x;
  logic [16:0] b_x;
  logic [16:0] r_x;

  assign a_x = {a_i[15], a_i};
  assign b_x = {b_i[15], b_i};

  always_comb begin
    r_x    = sub_i ? (a_x - b_x) : (a_x + b_x);
    ovfl_o = r_x[16] ^ r_x[15];
    sum_o  = r_x[15:0];
    // r_x[16] is the true sign of the unbounded result
    if (ovfl_o) begin
      sum_o = r_x[16] ? 16'h8000 : 16'h7FFF;
    end
  end
endmodule

module addsub_arbiter #(
  parameter bit FIXED_PRI = 1'b0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req0,
  input  logic [15:0] a0,
  input  logic [15:0] b0,
  input  logic        sub0,
  output logic        gnt0,
  output logic        rvalid0,
  output logic [15:0] rsum0,
  output logic        rovfl0,
  input  logic        rack0,
  input  logic        req1,
  input  logic [15:0] a1,
  input  logic [15:0] b1,
  input  logic        sub1,
  output logic        gnt1,
  output logic        rvalid1,
  output logic [15:0] rsum1,
  output logic        rovfl1,
  input  logic        rack1
);
  logic        rv0_q, rv0_d;
  logic        rv1_q, rv1_d;
  logic [15:0] sum0_q, sum0_d;
  logic [15:0] sum1_q, sum1_d;
  logic        ov0_q, ov0_d;
  logic        ov1_q, ov1_d;
  logic        last_q, last_d;

  logic        elig0, elig1, pick0;
  logic [15:0] op_a, op_b;
  logic        op_sub;
  logic [15:0] res;
  logic        res_ov;

  assign elig0 = req0 & (~rv0_q | rack0);
  assign elig1 = req1 & (~rv1_q | rack1);
  // last_q=1 means port 1 was served last, so port 0 wins a tie
  assign pick0 = elig0 & (~elig1 | FIXED_PRI | last_q);
  assign gnt0  = ~rst & pick0;
  assign gnt1  = ~rst & elig1 & ~pick0;

  assign op_a   = gnt1 ? a1 : a0;
  assign op_b   = gnt1 ? b1 : b0;
  assign op_sub = gnt1 ? sub1 : sub0;

  AddSub_16bit u_addsub (
    .a_i   (op_a),
    .b_i   (op_b),
    .sub_i (op_sub),
    .sum_o (res),
    .ovfl_o(res_ov)
  );

  always_comb begin
    rv0_d  = rv0_q;
    rv1_d  = rv1_q;
    sum0_d = sum0_q;
    sum1_d = sum1_q;
    ov0_d  = ov0_q;
    ov1_d  = ov1_q;
    last_d = last_q;
    if (gnt0) begin
      rv0_d  = 1'b1;
      sum0_d = res;
      ov0_d  = res_ov;
      last_d = 1'b0;
    end else if (rack0) begin
      rv0_d = 1'b0;
    end
    if (gnt1) begin
      rv1_d  = 1'b1;
      sum1_d = res;
      ov1_d  = res_ov;
      last_d = 1'b1;
    end else if (rack1) begin
      rv1_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rv0_q  <= 1'b0;
      rv1_q  <= 1'b0;
      sum0_q <= 16'h0000;
      sum1_q <= 16'h0000;
      ov0_q  <= 1'b0;
      ov1_q  <= 1'b0;
      last_q <= 1'b1;
    end else begin
      rv0_q  <= rv0_d;
      rv1_q  <= rv1_d;
      sum0_q <= sum0_d;
      sum1_q <= sum1_d;
      ov0_q  <= ov0_d;
      ov1_q  <= ov1_d;
      last_q <= last_d;
    end
  end

  assign rvalid0 = rv0_q;
  assign rvalid1 = rv1_q;
  assign rsum0   = sum0_q;
  assign rsum1   = sum1_q;
  assign rovfl0  = ov0_q;
  assign rovfl1  = ov1_q;
endmodule

// File: tb/tb_addsub_arbiter.sv
// Directed and random checks for addsub_arbiter.
// A second instance with FIXED_PRI=1 shares the inputs.
module tb_addsub_arbiter;
  logic        clk, rst;
  logic        req0, sub0, rack0;
  logic        req1, sub1, rack1;
  logic [15:0] a0, b0, a1, b1;
  logic        gnt0, rvalid0, rovfl0;
  logic        gnt1, rvalid1, rovfl1;
  logic [15:0] rsum0, rsum1;
  logic        p_gnt0, p_rv0, p_ov0;
  logic        p_gnt1, p_rv1, p_ov1;
  logic [15:0] p_sum0, p_sum1;

  int errs = 0;
  int checks = 0;

  addsub_arbiter #(.FIXED_PRI(1'b0)) dut (
    .clk(clk), .rst(rst),
    .req0(req0), .a0(a0), .b0(b0), .sub0(sub0),
    .gnt0(gnt0), .rvalid0(rvalid0), .rsum0(rsum0),
    .rovfl0(rovfl0), .rack0(rack0),
    .req1(req1), .a1(a1), .b1(b1), .sub1(sub1),
    .gnt1(gnt1), .rvalid1(rvalid1), .rsum1(rsum1),
    .rovfl1(rovfl1), .rack1(rack1)
  );

  addsub_arbiter #(.FIXED_PRI(1'b1)) dutp (
    .clk(clk), .rst(rst),
    .req0(req0), .a0(a0), .b0(b0), .sub0(sub0),
    .gnt0(p_gnt0), .rvalid0(p_rv0), .rsum0(p_sum0),
    .rovfl0(p_ov0), .rack0(rack0),
    .req1(req1), .a1(a1), .b1(b1), .sub1(sub1),
    .gnt1(p_gnt1), .rvalid1(p_rv1), .rsum1(p_sum1),
    .rovfl1(p_ov1), .rack1(rack1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [15:0] obs,
                     input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic sat(input logic [15:0] a,
                     input logic [15:0] b,
                     input logic s,
                     output logic [15:0] r,
                     output logic o);
    int x;
    x = s ? (int'($signed(a)) - int'($signed(b)))
          : (int'($signed(a)) + int'($signed(b)));
    if (x > 32767) begin
      r = 16'h7FFF; o = 1'b1;
    end else if (x < -32768) begin
      r = 16'h8000; o = 1'b1;
    end else begin
      r = x[15:0]; o = 1'b0;
    end
  endtask

  task automatic pulse_rst();
    rst = 1'b1;
    #2;
    rst = 1'b0;
  endtask

  logic        m_rv0, m_rv1, m_ov0, m_ov1, m_last;
  logic [15:0] m_s0, m_s1, r;
  logic        o, e0, e1, g0, g1;
  logic        want0;

  initial begin
    rst = 1'b1;
    {req0, sub0, rack0, req1, sub1, rack1} = '0;
    {a0, b0, a1, b1} = '0;
    #1;
    chk("rst_rvalid0", {15'd0, rvalid0}, 16'd0);
    chk("rst_rvalid1", {15'd0, rvalid1}, 16'd0);
    chk("rst_rsum0", rsum0, 16'h0000);
    chk("rst_rsum1", rsum1, 16'h0000);
    chk("rst_rovfl", {14'd0, rovfl0, rovfl1}, 16'd0);
    req0 = 1'b1;
    #1;
    chk("rst_gnt0_low", {15'd0, gnt0}, 16'd0);
    req0 = 1'b0;
    tick();
    tick();
    rst = 1'b0;

    req0 = 1'b1; a0 = 16'h1234; b0 = 16'h0101; sub0 = 1'b0;
    #1;
    chk("s1_gnt0", {15'd0, gnt0}, 16'd1);
    chk("s1_gnt1", {15'd0, gnt1}, 16'd0);
    tick();
    chk("s1_rvalid0", {15'd0, rvalid0}, 16'd1);
    chk("s1_rsum0", rsum0, 16'h1335);
    chk("s1_rovfl0", {15'd0, rovfl0}, 16'd0);

    req0 = 1'b0; rack0 = 1'b1;
    req1 = 1'b1; a1 = 16'h7000; b1 = 16'h2000; sub1 = 1'b0;
    #1;
    chk("s2_gnt1", {15'd0, gnt1}, 16'd1);
    tick();
    chk("s2_rvalid0", {15'd0, rvalid0}, 16'd0);
    chk("s2_rsum0_kept", rsum0, 16'h1335);
    chk("s2_rvalid1", {15'd0, rvalid1}, 16'd1);
    chk("s2_rsum1", rsum1, 16'h7FFF);
    chk("s2_rovfl1", {15'd0, rovfl1}, 16'd1);

    rack0 = 1'b0; rack1 = 1'b1;
    a1 = 16'h8000; b1 = 16'h0001; sub1 = 1'b1;
    #1;
    chk("s3_gnt1_b2b", {15'd0, gnt1}, 16'd1);
    tick();
    chk("s3_rvalid1", {15'd0, rvalid1}, 16'd1);
    chk("s3_rsum1", rsum1, 16'h8000);
    chk("s3_rovfl1", {15'd0, rovfl1}, 16'd1);

    req1 = 1'b0; rack0 = 1'b1;
    req0 = 1'b1; a0 = 16'h0005; b0 = 16'h0009; sub0 = 1'b1;
    #1;
    chk("s4_gnt0", {15'd0, gnt0}, 16'd1);
    chk("s4_gnt1", {15'd0, gnt1}, 16'd0);
    tick();
    chk("s4_rvalid1", {15'd0, rvalid1}, 16'd0);
    chk("s4_rsum0", rsum0, 16'hFFFC);
    chk("s4_rovfl0", {15'd0, rovfl0}, 16'd0);

    pulse_rst();
    req0 = 1'b1; req1 = 1'b1; rack0 = 1'b1; rack1 = 1'b1;
    for (int i = 0; i < 6; i++) begin
      #1;
      chk("rr_gnt0", {15'd0, gnt0}, (i % 2 == 0) ? 16'd1 : 16'd0);
      chk("rr_gnt1", {15'd0, gnt1}, (i % 2 == 0) ? 16'd0 : 16'd1);
      chk("fp_gnt0", {15'd0, p_gnt0}, 16'd1);
      chk("fp_gnt1", {15'd0, p_gnt1}, 16'd0);
      tick();
    end

    pulse_rst();
    req1 = 1'b0; rack0 = 1'b0; rack1 = 1'b1;
    req0 = 1'b1; a0 = 16'h0010; b0 = 16'h0020; sub0 = 1'b0;
    tick();
    chk("pd_rsum0", rsum0, 16'h0030);
    a0 = 16'h0100; b0 = 16'h0001;
    req1 = 1'b1; a1 = 16'h0001; b1 = 16'h0001; sub1 = 1'b0;
    for (int i = 0; i < 5; i++) begin
      #1;
      chk("pd_gnt0", {15'd0, gnt0}, 16'd0);
      chk("pd_gnt1", {15'd0, gnt1}, 16'd1);
      tick();
      chk("pd_hold_rsum0", rsum0, 16'h0030);
      chk("pd_hold_rv0", {15'd0, rvalid0}, 16'd1);
    end
    rack0 = 1'b1; req1 = 1'b0;
    #1;
    chk("pd_ack_gnt0", {15'd0, gnt0}, 16'd1);
    tick();
    chk("pd_ack_rv0", {15'd0, rvalid0}, 16'd1);
    chk("pd_ack_rsum0", rsum0, 16'h0101);

    req0 = 1'b0; rack0 = 1'b0; rack1 = 1'b0;
    req1 = 1'b1; a1 = 16'h0002; b1 = 16'h0003;
    tick();
    chk("ar_rv_both", {14'd0, rvalid0, rvalid1}, 16'd3);
    req0 = 1'b1; a0 = 16'h0002; b0 = 16'h0003; sub0 = 1'b0;
    #2;
    rst = 1'b1;
    #1;
    chk("ar_rv0", {15'd0, rvalid0}, 16'd0);
    chk("ar_rv1", {15'd0, rvalid1}, 16'd0);
    chk("ar_rsum0", rsum0, 16'h0000);
    chk("ar_rsum1", rsum1, 16'h0000);
    chk("ar_gnt", {14'd0, gnt0, gnt1}, 16'd0);
    tick();
    #2;
    rst = 1'b0;
    #1;
    chk("ar_first_gnt0", {15'd0, gnt0}, 16'd1);
    tick();
    chk("ar_first_rsum0", rsum0, 16'h0005);

    pulse_rst();
    m_rv0 = 0; m_rv1 = 0; m_ov0 = 0; m_ov1 = 0;
    m_s0 = 0; m_s1 = 0; m_last = 1;
    for (int i = 0; i < 200; i++) begin
      req0 = 1'($urandom_range(0, 1));
      req1 = 1'($urandom_range(0, 1));
      rack0 = 1'($urandom_range(0, 1));
      rack1 = 1'($urandom_range(0, 1));
      sub0 = 1'($urandom_range(0, 1));
      sub1 = 1'($urandom_range(0, 1));
      a0 = 16'($urandom); b0 = 16'($urandom);
      a1 = 16'($urandom); b1 = 16'($urandom);
      #1;
      e0 = req0 && (!m_rv0 || rack0);
      e1 = req1 && (!m_rv1 || rack1);
      want0 = e0 && (!e1 || m_last);
      g0 = want0;
      g1 = e1 && !want0;
      chk("rnd_onehot", {15'd0, gnt0 & gnt1}, 16'd0);
      chk("rnd_gnt0", {15'd0, gnt0}, {15'd0, g0});
      chk("rnd_gnt1", {15'd0, gnt1}, {15'd0, g1});
      if (g0) begin
        sat(a0, b0, sub0, r, o);
        m_s0 = r; m_ov0 = o; m_rv0 = 1; m_last = 0;
      end else if (rack0) begin
        m_rv0 = 0;
      end
      if (g1) begin
        sat(a1, b1, sub1, r, o);
        m_s1 = r; m_ov1 = o; m_rv1 = 1; m_last = 1;
      end else if (rack1) begin
        m_rv1 = 0;
      end
      tick();
      chk("rnd_rv0", {15'd0, rvalid0}, {15'd0, m_rv0});
      chk("rnd_rv1", {15'd0, rvalid1}, {15'd0, m_rv1});
      chk("rnd_rsum0", rsum0, m_s0);
      chk("rnd_rsum1", rsum1, m_s1);
      chk("rnd_rovfl0", {15'd0, rovfl0}, {15'd0, m_ov0});
      chk("rnd_rovfl1", {15'd0, rovfl1}, {15'd0, m_ov1});
    end

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
